// File: rtl/decode_inst_queue.sv
// decode_inst_queue: predecoding instruction buffer between fetch and issue.
// Branches are only presented together with their delay-slot instruction.
module decode_inst_queue #(
   parameter int DEPTH  = 16,
   parameter int PUSH_W = 2,
   parameter int POP_W  = 2,
   parameter int PC_W   = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic [PUSH_W-1:0]              in_valid,
   input  logic [32*PUSH_W-1:0]           in_instr,
   input  logic [PC_W*PUSH_W-1:0]         in_pc,
   output logic                           in_ready,
   output logic [POP_W-1:0]               out_valid,
   output logic [32*POP_W-1:0]            out_instr,
   output logic [PC_W*POP_W-1:0]          out_pc,
   output logic [POP_W-1:0]               out_is_branch,
   output logic [3*POP_W-1:0]             out_branch_type,
   output logic [POP_W-1:0]               out_undef,
   input  logic [$clog2(POP_W+1)-1:0]     pop_cnt,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           empty,
   output logic                           full
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int NW = $clog2(PUSH_W+1);
   localparam int PW = $clog2(POP_W+1);

   logic [31:0]     r_instr [DEPTH];
   logic [PC_W-1:0] r_pc    [DEPTH];
   logic [2:0]      r_type  [DEPTH];
   logic            r_br    [DEPTH];
   logic            r_undef [DEPTH];
   logic [AW-1:0]   r_head, r_tail;
   logic [CW-1:0]   r_count;

   logic [2:0]      w_type  [PUSH_W];
   logic            w_undef [PUSH_W];
   logic [AW-1:0]   w_off   [PUSH_W];
   logic [NW-1:0]   w_npush;
   logic            w_push;
   logic [PW-1:0]   w_nvalid, w_pop;
   logic            w_ok;

   function automatic logic [2:0] f_type(input logic [31:0] ins);
      return ins[31:28] == 4'b0001                              ? 3'd1 :
             ins[31:26] == 6'b000001 && ins[19:17] == 3'b000    ? 3'd2 :
             ins[31:27] == 5'b00001                             ? 3'd3 :
             ins[31:26] == 6'b000000 && ins[5:1] == 5'b00100    ? 3'd4 : 3'd0;
   endfunction

   function automatic logic f_undef(input logic [31:0] ins);
      logic [5:0] op;
      op = ins[31:26];
      return !(op[5:4] == 2'b00 ||
               op inside {6'h10, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B});
   endfunction

   assign in_ready = r_count <= CW'(DEPTH - PUSH_W);
   assign count    = r_count;
   assign empty    = r_count == '0;
   assign full     = r_count == CW'(DEPTH);
   assign w_push   = in_ready && |in_valid && !flush;

   // Lane offsets are prefix counts so lanes pack densely at the tail.
   always_comb begin
      w_npush = '0;
      for (int i = 0; i < PUSH_W; i++) begin
         w_type[i]  = f_type(in_instr[32*i +: 32]);
         w_undef[i] = f_undef(in_instr[32*i +: 32]);
         w_off[i]   = AW'(w_npush);
         w_npush    = w_npush + NW'(in_valid[i]);
      end
   end

   // A branch is presentable only if its delay slot is buffered in the same group.
   always_comb begin
      w_ok     = 1'b1;
      w_nvalid = '0;
      for (int i = 0; i < POP_W; i++) begin
         out_instr[32*i +: 32]         = r_instr[r_head + AW'(i)];
         out_pc[PC_W*i +: PC_W]        = r_pc[r_head + AW'(i)];
         out_branch_type[3*i +: 3]     = r_type[r_head + AW'(i)];
         out_is_branch[i]              = r_br[r_head + AW'(i)];
         out_undef[i]                  = r_undef[r_head + AW'(i)];
         out_valid[i] = w_ok && CW'(i) < r_count &&
                        (!r_br[r_head + AW'(i)] || (i + 1 < POP_W && CW'(i + 1) < r_count));
         w_ok     = out_valid[i];
         w_nvalid = w_nvalid + PW'(out_valid[i]);
      end
      w_pop = pop_cnt > w_nvalid ? w_nvalid : pop_cnt;
   end

   always_ff @(posedge clk)
      if (rst || flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + AW'(w_pop);
         r_tail  <= r_tail + (w_push ? AW'(w_npush) : '0);
         r_count <= r_count + (w_push ? CW'(w_npush) : '0) - CW'(w_pop);
      end

   always_ff @(posedge clk)
      for (int i = 0; i < PUSH_W; i++)
         if (w_push && in_valid[i]) begin
            r_instr[r_tail + w_off[i]] <= in_instr[32*i +: 32];
            r_pc[r_tail + w_off[i]]    <= in_pc[PC_W*i +: PC_W];
            r_type[r_tail + w_off[i]]  <= w_type[i];
            r_br[r_tail + w_off[i]]    <= w_type[i] != 3'd0;
            r_undef[r_tail + w_off[i]] <= w_undef[i];
         end
endmodule

// File: tb/tb_decode_inst_queue.sv
// tb_decode_inst_queue: scoreboard bench with a queue-based reference model of the buffer.
module tb_decode_inst_queue;
   localparam int DEPTH = 16, PUSH_W = 2, POP_W = 2, PC_W = 32;

   logic        clk = 0, rst = 1, flush = 0;
   logic [1:0]  in_valid = 0, pop_cnt = 0;
   logic [63:0] in_instr = 0, in_pc = 0;
   logic        in_ready, empty, full;
   logic [1:0]  out_valid, out_is_branch, out_undef;
   logic [63:0] out_instr, out_pc;
   logic [5:0]  out_branch_type;
   logic [4:0]  count;

   decode_inst_queue #(.DEPTH(DEPTH), .PUSH_W(PUSH_W), .POP_W(POP_W), .PC_W(PC_W)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_instr(in_instr),
      .in_pc(in_pc), .in_ready(in_ready), .out_valid(out_valid), .out_instr(out_instr),
      .out_pc(out_pc), .out_is_branch(out_is_branch), .out_branch_type(out_branch_type),
      .out_undef(out_undef), .pop_cnt(pop_cnt), .count(count), .empty(empty), .full(full));

   always #5 clk = ~clk;

   typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
   typedef struct {
      int cnt; logic [1:0] vld; logic rdy;
      logic [31:0] i0, i1, p0, p1;
   } exp_t;

   ent_t mq[$];
   exp_t sb[$];
   int   n_cmp = 0, n_bad = 0;

   localparam logic [31:0] ADDU = 32'h00851021, ORI = 32'h34420001, BEQ = 32'h10850003,
                           JR = 32'h03E00008, NOP = 32'h0, BGEZAL = 32'h04110004,
                           RIMM1F = 32'h041F0004;

   function automatic logic [2:0] ref_type(input logic [31:0] w);
      case (w[31:26])
         6'd4, 6'd5, 6'd6, 6'd7: return 3'd1;
         6'd1:                   return (w[20:16] inside {5'd0, 5'd1, 5'd16, 5'd17}) ? 3'd2 : 3'd0;
         6'd2, 6'd3:             return 3'd3;
         6'd0:                   return (w[5:0] == 6'h08 || w[5:0] == 6'h09) ? 3'd4 : 3'd0;
         default:                return 3'd0;
      endcase
   endfunction

   function automatic logic ref_undef(input logic [31:0] w);
      logic [5:0] op;
      op = w[31:26];
      return !(op <= 6'h10 || op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B});
   endfunction

   function automatic int ref_nvalid();
      int n = 0;
      for (int i = 0; i < POP_W; i++) begin
         if (i < mq.size() && (ref_type(mq[i].instr) == 0 || (i + 1 < POP_W && i + 1 < mq.size())))
            n++;
         else
            break;
      end
      return n;
   endfunction

   function automatic logic [31:0] pick(input int k);
      case (k)
         0: return ADDU;         1: return ORI;          2: return BEQ;
         3: return 32'h14400002; 4: return 32'h18400001; 5: return 32'h1C400001;
         6: return BGEZAL;       7: return RIMM1F;       8: return 32'h08000010;
         9: return 32'h0C000010; 10: return JR;          11: return 32'h8C820000;
         12: return 32'hAC820000; 13: return $urandom;   14: return 32'hFC000000;
         default: return 32'h0040F809;
      endcase
   endfunction

   task automatic cyc(input logic f, input logic r, input logic [1:0] v,
                      input logic [31:0] i0, input logic [31:0] p0,
                      input logic [31:0] i1, input logic [31:0] p1, input logic [1:0] pc);
      exp_t x;
      int nv, popped;
      @(negedge clk);
      nv    = ref_nvalid();
      x.cnt = mq.size();
      x.vld = nv == 2 ? 2'b11 : nv == 1 ? 2'b01 : 2'b00;
      x.rdy = mq.size() <= DEPTH - PUSH_W;
      x.i0  = mq.size() > 0 ? mq[0].instr : 0;
      x.p0  = mq.size() > 0 ? mq[0].pc : 0;
      x.i1  = mq.size() > 1 ? mq[1].instr : 0;
      x.p1  = mq.size() > 1 ? mq[1].pc : 0;
      sb.push_back(x);
      flush = f; rst = r; in_valid = v; pop_cnt = pc;
      in_instr = {i1, i0}; in_pc = {p1, p0};
      if (f || r) mq.delete();
      else begin
         popped = int'(pc) < nv ? int'(pc) : nv;
         repeat (popped) void'(mq.pop_front());
         if (x.rdy) begin
            if (v[0]) mq.push_back('{i0, p0});
            if (v[1]) mq.push_back('{i1, p1});
         end
      end
   endtask

   task automatic idle(input logic [1:0] pc);
      cyc(0, 0, 2'b00, 0, 0, 0, 0, pc);
   endtask

   task automatic chk_lane(input int l, input logic [31:0] ei, input logic [31:0] ep);
      logic [31:0] gi, gp;
      logic [2:0]  gt;
      gi = out_instr[32*l +: 32];
      gp = out_pc[32*l +: 32];
      gt = out_branch_type[3*l +: 3];
      n_cmp++;
      if (gi !== ei || gp !== ep || gt !== ref_type(ei) || out_is_branch[l] !== (ref_type(ei) != 0) ||
          out_undef[l] !== ref_undef(ei)) begin
         n_bad++;
         $display("FAIL lane%0d: got instr=%h pc=%h type=%0d br=%b undef=%b, expected instr=%h pc=%h type=%0d br=%b undef=%b",
                  l, gi, gp, gt, out_is_branch[l], out_undef[l], ei, ep, ref_type(ei),
                  ref_type(ei) != 0, ref_undef(ei));
      end
   endtask

   initial forever begin
      exp_t x;
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
         x = sb.pop_front();
         n_cmp++;
         if (int'(count) != x.cnt || empty !== (x.cnt == 0) || full !== (x.cnt == DEPTH) ||
             in_ready !== x.rdy || out_valid !== x.vld) begin
            n_bad++;
            $display("FAIL status: got count=%0d empty=%b full=%b ready=%b valid=%b, expected count=%0d empty=%b full=%b ready=%b valid=%b",
                     count, empty, full, in_ready, out_valid, x.cnt, x.cnt == 0, x.cnt == DEPTH, x.rdy, x.vld);
         end
         if (x.vld[0]) chk_lane(0, x.i0, x.p0);
         if (x.vld[1]) chk_lane(1, x.i1, x.p1);
      end
   end

   initial begin
      logic [31:0] pcv;
      logic [1:0]  vv;
      repeat (2) @(posedge clk);
      idle(0);
      cyc(0, 0, 2'b11, ADDU, 32'hBFC00000, ORI, 32'hBFC00004, 0);
      idle(2);
      idle(0);
      cyc(0, 0, 2'b01, BEQ, 32'hBFC00008, 0, 0, 0);
      cyc(0, 0, 2'b01, NOP, 32'hBFC0000C, 0, 0, 0);
      idle(0);
      idle(2);
      cyc(0, 0, 2'b11, ADDU, 32'hBFC00010, JR, 32'hBFC00014, 0);
      cyc(0, 0, 2'b01, NOP, 32'hBFC00018, 0, 0, 0);
      idle(1);
      idle(0);
      idle(2);
      pcv = 32'hBFC00100;
      for (int k = 0; k < 8; k++) begin
         cyc(0, 0, 2'b11, ADDU, pcv, ORI, pcv + 4, 0);
         pcv += 8;
      end
      cyc(0, 0, 2'b11, ADDU, 32'hDEAD0000, ORI, 32'hDEAD0004, 0);
      idle(2);
      cyc(0, 0, 2'b11, ADDU, pcv, ORI, pcv + 4, 2);
      pcv += 8;
      idle(3);
      idle(0);
      cyc(1, 0, 2'b11, ADDU, pcv, ORI, pcv + 4, 0);
      idle(0);
      cyc(0, 0, 2'b11, ADDU, pcv, ORI, pcv + 4, 0);
      cyc(0, 1, 2'b11, ADDU, pcv + 8, ORI, pcv + 12, 1);
      idle(0);
      cyc(0, 0, 2'b11, BGEZAL, 32'hBFC00200, NOP, 32'hBFC00204, 0);
      cyc(0, 0, 2'b11, RIMM1F, 32'hBFC00208, ADDU, 32'hBFC0020C, 0);
      idle(2);
      idle(2);
      pcv = 32'hBFC00300;
      for (int k = 0; k < 40; k++) begin
         vv = $urandom_range(0, 2) == 0 ? 2'b01 : 2'b11;
         cyc(0, 0, vv, pick($urandom_range(0, 15)), pcv, pick($urandom_range(0, 15)), pcv + 4,
             2'($urandom_range(0, 3)));
         pcv += 8;
      end
      for (int k = 0; k < 300; k++) begin
         vv = 2'($urandom_range(0, 2));
         if (vv == 2'b10) vv = 2'b11;
         cyc($urandom_range(0, 39) == 0, 0, vv, pick($urandom_range(0, 15)), pcv,
             pick($urandom_range(0, 15)), pcv + 4, 2'($urandom_range(0, 3)));
         pcv += 8;
      end
      repeat (20) idle(3);
      repeat (3) @(negedge clk);
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
